// File: rtl/minisrc_bus_pkg.sv
// Shared constants and helpers for the minisrc bus muxes.
package minisrc_bus_pkg;

  localparam int unsigned ARB_MODE_RR       = 0;
  localparam int unsigned ARB_MODE_FIXED    = 1;
  localparam int unsigned BUS_WIDTH_DEFAULT = 32;

  // Ceiling log2, used to size source-index fields.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin / fixed-priority arbiter with one-hot grant.
// Optional burst lock enabled by macro ARB_BUS_MUX_LOCK_EN.
module rr_arbiter
  import minisrc_bus_pkg::*;
#(
  parameter int unsigned N_IN = 4,
  parameter int unsigned MODE = ARB_MODE_RR
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_IN-1:0] req,
  input  logic            advance,
`ifdef ARB_BUS_MUX_LOCK_EN
  input  logic            last,
`endif
  output logic [N_IN-1:0] grant
);

  localparam int unsigned SRC_W = clog2(N_IN);

  logic [SRC_W-1:0] ptr;
  logic [SRC_W-1:0] ptr_next;
  logic [SRC_W-1:0] ptr_inc;
  logic [SRC_W-1:0] start;
  logic [SRC_W-1:0] gidx;
  logic             found;
  int unsigned      idx;

`ifdef ARB_BUS_MUX_LOCK_EN
  typedef enum logic {ST_OPEN, ST_LOCKED} lock_state_t;
  lock_state_t      state;
  lock_state_t      state_next;
  logic [SRC_W-1:0] lock_src;
  logic [SRC_W-1:0] lock_src_next;
`endif

  // First requester at or after the start index, wrapping modulo N_IN.
  always_comb begin : search
    start = (MODE == ARB_MODE_FIXED) ? '0 : ptr;
    gidx  = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned i = 0; i < N_IN; i++) begin
      idx = 32'(start) + i;
      if (idx >= N_IN) idx = idx - N_IN;
      if (!found && req[SRC_W'(idx)]) begin
        found = 1'b1;
        gidx  = SRC_W'(idx);
      end
    end
`ifdef ARB_BUS_MUX_LOCK_EN
    // A locked burst owner is the only candidate, even while it is idle.
    if (state == ST_LOCKED) begin
      gidx  = lock_src;
      found = req[lock_src];
    end
`endif
    grant = found ? (N_IN'(1) << gidx) : '0;
  end

  assign ptr_inc = (gidx == SRC_W'(N_IN - 1)) ? '0 : gidx + 1'b1;

  always_comb begin : next_state
    ptr_next = ptr;
`ifdef ARB_BUS_MUX_LOCK_EN
    state_next    = state;
    lock_src_next = lock_src;
    if (advance) begin
      if (!last) begin
        state_next    = ST_LOCKED;
        lock_src_next = gidx;
      end else begin
        state_next = ST_OPEN;
        ptr_next   = ptr_inc;
      end
    end
`else
    if (advance) ptr_next = ptr_inc;
`endif
    if (MODE == ARB_MODE_FIXED) ptr_next = '0;
  end

  always_ff @(posedge clk) begin : state_reg
    if (!rst_n) begin
      ptr <= '0;
`ifdef ARB_BUS_MUX_LOCK_EN
      state    <= ST_OPEN;
      lock_src <= '0;
`endif
    end else begin
      ptr <= ptr_next;
`ifdef ARB_BUS_MUX_LOCK_EN
      state    <= state_next;
      lock_src <= lock_src_next;
`endif
    end
  end

endmodule

// File: rtl/arb_bus_mux.sv
// N-input bus mux with valid/ready handshake, built-in arbitration and a registered output.
// Macro ARB_BUS_MUX_LOCK_EN adds in_last and burst locking.
module arb_bus_mux
  import minisrc_bus_pkg::*;
#(
  parameter  int unsigned WIDTH = BUS_WIDTH_DEFAULT,
  parameter  int unsigned N_IN  = 4,
  parameter  int unsigned MODE  = ARB_MODE_RR,
  localparam int unsigned SRC_W = clog2(N_IN)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_IN*WIDTH-1:0] in_data,
  input  logic [N_IN-1:0]       in_valid,
  output logic [N_IN-1:0]       in_ready,
`ifdef ARB_BUS_MUX_LOCK_EN
  input  logic [N_IN-1:0]       in_last,
`endif
  output logic [WIDTH-1:0]      out_data,
  output logic [SRC_W-1:0]      out_src,
  output logic                  out_valid,
  input  logic                  out_ready
);

  logic [N_IN-1:0]  grant;
  logic             accept;
  logic             take;
  logic [WIDTH-1:0] chan [N_IN];
  logic [WIDTH-1:0] sel_data;
  logic [SRC_W-1:0] sel_src;

  for (genvar g = 0; g < N_IN; g++) begin : g_chan
    assign chan[g] = in_data[g*WIDTH +: WIDTH];
  end

  // Output register can take a beat when empty or draining this cycle.
  assign accept   = ~out_valid | out_ready;
  assign take     = rst_n & accept & (|grant);
  assign in_ready = take ? grant : '0;

  always_comb begin : select
    sel_data = '0;
    sel_src  = '0;
    for (int unsigned i = 0; i < N_IN; i++) begin
      if (grant[SRC_W'(i)]) begin
        sel_data = chan[SRC_W'(i)];
        sel_src  = SRC_W'(i);
      end
    end
  end

  rr_arbiter #(
    .N_IN (N_IN),
    .MODE (MODE)
  ) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (in_valid),
    .advance (take),
`ifdef ARB_BUS_MUX_LOCK_EN
    .last    (|(in_last & grant)),
`endif
    .grant   (grant)
  );

  always_ff @(posedge clk) begin : out_stage
    if (!rst_n) begin
      out_data  <= '0;
      out_src   <= '0;
      out_valid <= 1'b0;
    end else if (take) begin
      out_data  <= sel_data;
      out_src   <= sel_src;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_arb_bus_mux.sv
// Scoreboard bench for arb_bus_mux: round-robin and fixed-priority instances side by side.
module tb_arb_bus_mux;

  localparam int unsigned W  = 32;
  localparam int unsigned N  = 4;
  localparam int unsigned SW = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N*W-1:0]  in_data;
  logic [N-1:0]    v0, v1, ir0, ir1;
  logic            r0, r1;
  logic [W-1:0]    d0, d1;
  logic [SW-1:0]   s0, s1;
  logic            ov0, ov1;
`ifdef ARB_BUS_MUX_LOCK_EN
  logic [N-1:0]    l0, l1;
`endif

  int checks = 0;
  int errors = 0;
  logic [SW+W-1:0] q0[$];
  logic [SW+W-1:0] q1[$];

  always #5 clk = ~clk;

  arb_bus_mux #(.WIDTH(W), .N_IN(N), .MODE(0)) u_rr (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(v0), .in_ready(ir0),
`ifdef ARB_BUS_MUX_LOCK_EN
    .in_last(l0),
`endif
    .out_data(d0), .out_src(s0), .out_valid(ov0), .out_ready(r0)
  );

  arb_bus_mux #(.WIDTH(W), .N_IN(N), .MODE(1)) u_fx (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(v1), .in_ready(ir1),
`ifdef ARB_BUS_MUX_LOCK_EN
    .in_last(l1),
`endif
    .out_data(d1), .out_src(s1), .out_valid(ov1), .out_ready(r1)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Expected beat for channel c: {source index, 32'hA000_000c}.
  function automatic logic [SW+W-1:0] beat(input int c);
    return {SW'(c), 32'hA000_0000 + 32'(c)};
  endfunction

  // Monitors pop one expected beat per output handshake.
  always @(negedge clk) begin : mon0
    logic [SW+W-1:0] e;
    if (rst_n === 1'b1 && ov0 === 1'b1 && r0 === 1'b1) begin
      if (q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL rr_unexpected_beat actual src=%0d data=%0h required none", s0, d0);
      end else begin
        e = q0.pop_front();
        chk("rr_beat", 64'({s0, d0}), 64'(e));
      end
    end
  end

  always @(negedge clk) begin : mon1
    logic [SW+W-1:0] e;
    if (rst_n === 1'b1 && ov1 === 1'b1 && r1 === 1'b1) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL fx_unexpected_beat actual src=%0d data=%0h required none", s1, d1);
      end else begin
        e = q1.pop_front();
        chk("fx_beat", 64'({s1, d1}), 64'(e));
      end
    end
  end

  initial begin
    int exp_src [5] = '{0, 1, 2, 3, 0};
    in_data = {32'hA000_0003, 32'hA000_0002, 32'hA000_0001, 32'hA000_0000};
    rst_n = 1'b0; v0 = 4'hF; v1 = 4'hF; r0 = 1'b1; r1 = 1'b1;
`ifdef ARB_BUS_MUX_LOCK_EN
    l0 = 4'b0000; l1 = 4'b1111;
`endif

    // Reset with every input valid.
    cyc(); cyc();
    chk("rst_in_ready_rr", 64'(ir0), 64'h0);
    chk("rst_in_ready_fx", 64'(ir1), 64'h0);
    chk("rst_out_valid", 64'(ov0), 64'h0);
    chk("rst_out_data", 64'(d0), 64'h0);
    chk("rst_out_src", 64'(s0), 64'h0);
    rst_n = 1'b1; v1 = 4'b0000;
    #1 chk("first_grant_ch0", 64'(ir0), 64'b0001);

    // Round-robin with all channels valid: 0,1,2,3,0 back to back.
    for (int k = 0; k < 5; k++) q0.push_back(beat(exp_src[k]));
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("rr_no_bubble", 64'(ov0), 64'h1);
      chk("rr_src_seq", 64'(s0), 64'(exp_src[k]));
    end

    // Backpressure: output frozen, no grants.
    r0 = 1'b0;
    #1 chk("bp_in_ready", 64'(ir0), 64'h0);
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("bp_in_ready_hold", 64'(ir0), 64'h0);
      chk("bp_data_hold", 64'(d0), 64'hA000_0000);
      chk("bp_src_hold", 64'(s0), 64'h0);
      chk("bp_valid_hold", 64'(ov0), 64'h1);
    end
    r0 = 1'b1;
    q0.push_back(beat(1));
    q0.push_back(beat(2));
    #1 chk("bp_resume_ptr", 64'(ir0), 64'b0010);
    cyc(); chk("bp_resume_src1", 64'(s0), 64'h1);
    cyc(); chk("bp_resume_src2", 64'(s0), 64'h2);

    // Wrap from pointer 3 to a sparse request on channel 0.
    v0 = 4'b0001;
    q0.push_back(beat(0));
    #1 chk("wrap_grant0", 64'(ir0), 64'b0001);
    cyc(); chk("wrap_src0", 64'(s0), 64'h0);
    v0 = 4'b0000;
    #1 chk("idle_in_ready", 64'(ir0), 64'h0);
    cyc(); chk("drain_valid_low", 64'(ov0), 64'h0);
    // Pointer should now be 1, so channel 1 beats channel 0.
    v0 = 4'b0011;
    q0.push_back(beat(1));
    #1 chk("wrap_ptr_is_1", 64'(ir0), 64'b0010);
    cyc(); chk("wrap_ptr_src1", 64'(s0), 64'h1);
    v0 = 4'b0000;
    cyc(); chk("drain2_valid_low", 64'(ov0), 64'h0);

    // Fixed priority: channel 1 starves channel 3 until it drops.
    v1 = 4'b1010;
    for (int k = 0; k < 3; k++) q1.push_back(beat(1));
    #1 chk("fx_grant1", 64'(ir1), 64'b0010);
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("fx_src1", 64'(s1), 64'h1);
      if (k < 2) chk("fx_ready1", 64'(ir1), 64'b0010);
    end
    v1 = 4'b1000;
    q1.push_back(beat(3));
    #1 chk("fx_grant3", 64'(ir1), 64'b1000);
    cyc(); chk("fx_src3", 64'(s1), 64'h3);
    v1 = 4'b0000;
    cyc(); chk("fx_drain", 64'(ov1), 64'h0);

`ifdef ARB_BUS_MUX_LOCK_EN
    // Burst on channel 2 (pointer 2) holds off channel 0, even while idle.
    v0 = 4'b0101; l0 = 4'b0000;
    q0.push_back(beat(2));
    #1 chk("lock_first", 64'(ir0), 64'b0100);
    cyc(); chk("lock_src_b1", 64'(s0), 64'h2);
    v0 = 4'b0001;
    #1 chk("lock_idle_owner", 64'(ir0), 64'h0);
    cyc();
    v0 = 4'b0101;
    q0.push_back(beat(2));
    #1 chk("lock_resume", 64'(ir0), 64'b0100);
    cyc(); chk("lock_src_b2", 64'(s0), 64'h2);
    l0 = 4'b0100;
    q0.push_back(beat(2));
    cyc(); chk("lock_src_b3", 64'(s0), 64'h2);
    l0 = 4'b0001;
    q0.push_back(beat(0));
    #1 chk("lock_released", 64'(ir0), 64'b0001);
    cyc(); chk("lock_src_after", 64'(s0), 64'h0);
    // Start a burst on channel 1, then reset mid-burst; the held beat is dropped.
    v0 = 4'b0110; l0 = 4'b0000;
    cyc();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1; v0 = 4'b0101; l0 = 4'b0001;
    chk("mid_rst_valid", 64'(ov0), 64'h0);
    q0.push_back(beat(0));
    #1 chk("mid_rst_ptr0", 64'(ir0), 64'b0001);
    cyc(); chk("mid_rst_src0", 64'(s0), 64'h0);
    v0 = 4'b0000;
    cyc(); chk("mid_rst_drain", 64'(ov0), 64'h0);
`endif

    cyc(); cyc();
    chk("rr_queue_empty", 64'(q0.size()), 64'h0);
    chk("fx_queue_empty", 64'(q1.size()), 64'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
